// File: rtl/memory_turn_controller.sv
// Turn sequencer for a two-player pairs game on a COLS x ROWS card grid.
// Owns cursor, face-up/matched masks, scores, turn timer and mismatch hold.
module memory_turn_controller #(
  parameter int COLS        = 10,
  parameter int ROWS        = 5,
  parameter int N_CELLS     = 50,
  parameter int VAL_W       = 5,
  parameter int TURN_CYCLES = 250000000,
  parameter int SHOW_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mv_left,
  input  logic               mv_right,
  input  logic               mv_up,
  input  logic               mv_down,
  input  logic               sel,
  output logic [5:0]         val_addr,
  input  logic [VAL_W-1:0]   val_data,
  output logic [5:0]         cursor,
  output logic [N_CELLS-1:0] revealed,
  output logic [N_CELLS-1:0] matched,
  output logic               player,
  output logic [4:0]         score_p1,
  output logic [4:0]         score_p2,
  output logic [3:0]         timer_left,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [2:0]         fsm_state
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [27:0]      TURN_LOAD = 28'(TURN_CYCLES - 1);
  localparam logic [27:0]      SHOW_LOAD = 28'(SHOW_CYCLES - 1);
  localparam logic [27:0]      SEC_DIV   = 28'((TURN_CYCLES / 10 > 0) ? TURN_CYCLES / 10 : 1);
  localparam logic [4:0]       MAX_SCORE = 5'd25;

  typedef enum logic [2:0] {IDLE, PICK1, PICK2, CHECK, SHOW, GAME_OVER} state_t;

  state_t             state, next_state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [5:0]         idx_a, idx_b;
  logic [VAL_W-1:0]   val_a, val_b;
  logic [27:0]        turn_cnt, show_cnt;
  logic [27:0]        secs;
  logic [N_CELLS-1:0] pair_bits;
  logic               start_game, picking, timeout, sel_ok, pick_ok;
  logic               pair_match, all_matched, show_done;

  assign cursor    = 6'(32'(row) * COLS + 32'(col));
  assign val_addr  = cursor;
  assign fsm_state = state;

  assign start_game  = start && (state == IDLE || state == GAME_OVER);
  assign picking     = (state == PICK1) || (state == PICK2);
  // turn_cnt holds the cycles left after the current one; zero means this is the last
  assign timeout     = picking && (turn_cnt == '0);
  assign sel_ok      = sel && !revealed[cursor] && !matched[cursor];
  assign pick_ok     = sel_ok && !timeout;
  assign pair_bits   = (N_CELLS'(1) << idx_a) | (N_CELLS'(1) << idx_b);
  assign pair_match  = (val_a == val_b);
  assign all_matched = ((matched | pair_bits) == {N_CELLS{1'b1}});
  assign show_done   = (state == SHOW) && (show_cnt == '0);

  assign secs       = turn_cnt / SEC_DIV;
  assign timer_left = (secs > 28'd15) ? 4'd15 : secs[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, GAME_OVER: if (start) next_state = PICK1;
      PICK1: begin
        if (timeout)      next_state = PICK1;
        else if (pick_ok) next_state = PICK2;
      end
      PICK2: begin
        if (timeout)      next_state = PICK1;
        else if (pick_ok) next_state = CHECK;
      end
      CHECK: begin
        if (!pair_match)      next_state = SHOW;
        else if (all_matched) next_state = GAME_OVER;
        else                  next_state = PICK1;
      end
      SHOW: if (show_done) next_state = PICK1;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    game_over = (state == GAME_OVER);
    winner    = 2'b00;
    if (state == GAME_OVER) begin
      if (score_p1 > score_p2)      winner = 2'b01;
      else if (score_p2 > score_p1) winner = 2'b10;
      else                          winner = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      revealed <= '0;
      matched  <= '0;
      player   <= 1'b0;
      score_p1 <= '0;
      score_p2 <= '0;
      idx_a    <= '0;
      idx_b    <= '0;
      val_a    <= '0;
      val_b    <= '0;
      turn_cnt <= '0;
      show_cnt <= '0;
    end else if (start_game) begin
      col      <= '0;
      row      <= '0;
      revealed <= '0;
      matched  <= '0;
      player   <= 1'b0;
      score_p1 <= '0;
      score_p2 <= '0;
      turn_cnt <= TURN_LOAD;
      show_cnt <= '0;
    end else begin
      // Selection below samples the pre-move cursor; the move lands on the same edge
      if (state != IDLE) begin
        if (mv_left)       col <= (col == '0) ? COL_MAX : col - COL_W'(1);
        else if (mv_right) col <= (col == COL_MAX) ? '0 : col + COL_W'(1);
        else if (mv_up)    row <= (row == '0) ? ROW_MAX : row - ROW_W'(1);
        else if (mv_down)  row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
      end
      case (state)
        PICK1, PICK2: begin
          if (timeout) begin
            revealed <= '0;
            player   <= ~player;
            turn_cnt <= TURN_LOAD;
          end else begin
            turn_cnt <= turn_cnt - 28'd1;
            if (pick_ok) begin
              revealed[cursor] <= 1'b1;
              if (state == PICK1) begin
                idx_a <= cursor;
                val_a <= val_data;
              end else begin
                idx_b <= cursor;
                val_b <= val_data;
              end
            end
          end
        end
        CHECK: begin
          if (pair_match) begin
            matched  <= matched | pair_bits;
            revealed <= revealed & ~pair_bits;
            if (!player) begin
              if (score_p1 != MAX_SCORE) score_p1 <= score_p1 + 5'd1;
            end else begin
              if (score_p2 != MAX_SCORE) score_p2 <= score_p2 + 5'd1;
            end
            if (!all_matched) turn_cnt <= TURN_LOAD;
          end else begin
            show_cnt <= SHOW_LOAD;
          end
        end
        SHOW: begin
          if (show_done) begin
            revealed <= revealed & ~pair_bits;
            player   <= ~player;
            turn_cnt <= TURN_LOAD;
          end else begin
            show_cnt <= show_cnt - 28'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_turn_controller.sv
// Bench for memory_turn_controller: cursor vector table, scripted corner cases,
// then random play against a cell-array game model.
module tb_memory_turn_controller;

  localparam int COLS        = 10;
  localparam int ROWS        = 5;
  localparam int N_CELLS     = 50;
  localparam int VAL_W       = 5;
  localparam int TURN_CYCLES = 40;
  localparam int SHOW_CYCLES = 8;
  localparam int SEC_DIV     = TURN_CYCLES / 10;
  localparam int OUT_W       = 124;

  localparam int PH_IDLE = 0, PH_FIRST = 1, PH_SECOND = 2, PH_JUDGE = 3, PH_HOLD = 4, PH_OVER = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, mv_left, mv_right, mv_up, mv_down, sel;
  logic [5:0]         val_addr;
  logic [VAL_W-1:0]   val_data;
  logic [5:0]         cursor;
  logic [N_CELLS-1:0] revealed, matched;
  logic               player;
  logic [4:0]         score_p1, score_p2;
  logic [3:0]         timer_left;
  logic               game_over;
  logic [1:0]         winner;
  logic [2:0]         fsm_state;
  logic [VAL_W-1:0]   rom [64];

  assign val_data = rom[val_addr];

  always #5 clk = ~clk;

  memory_turn_controller #(
    .COLS(COLS), .ROWS(ROWS), .N_CELLS(N_CELLS), .VAL_W(VAL_W),
    .TURN_CYCLES(TURN_CYCLES), .SHOW_CYCLES(SHOW_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mv_left(mv_left), .mv_right(mv_right), .mv_up(mv_up), .mv_down(mv_down),
    .sel(sel), .val_addr(val_addr), .val_data(val_data), .cursor(cursor),
    .revealed(revealed), .matched(matched), .player(player),
    .score_p1(score_p1), .score_p2(score_p2), .timer_left(timer_left),
    .game_over(game_over), .winner(winner), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: one flag per cell, cursor as row/col, turn budget in whole cycles
  int m_phase, m_row, m_col, m_player, m_turn, m_show, m_a, m_b, m_va, m_vb;
  int m_score [2];
  bit m_rev [N_CELLS];
  bit m_mat [N_CELLS];

  typedef struct {
    bit st, l, r, u, d, s;
    int exp_cursor;
    logic [N_CELLS-1:0] exp_rev;
  } vec_t;
  vec_t vecs [23];

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_row = 0; m_col = 0; m_player = 0; m_turn = 1; m_show = 0;
    m_a = 0; m_b = 0; m_va = 0; m_vb = 0; m_score[0] = 0; m_score[1] = 0;
    for (int i = 0; i < N_CELLS; i++) begin m_rev[i] = 0; m_mat[i] = 0; end
  endtask

  task automatic model_step(input bit st, l, r, u, d, s);
    int cur;
    bit can_sel, expired, all;
    cur     = m_row * COLS + m_col;
    can_sel = s && !m_rev[cur] && !m_mat[cur];
    expired = (m_phase == PH_FIRST || m_phase == PH_SECOND) && m_turn == 1;
    if (st && (m_phase == PH_IDLE || m_phase == PH_OVER)) begin
      for (int i = 0; i < N_CELLS; i++) begin m_rev[i] = 0; m_mat[i] = 0; end
      m_player = 0; m_score[0] = 0; m_score[1] = 0;
      m_row = 0; m_col = 0; m_turn = TURN_CYCLES; m_phase = PH_FIRST;
    end else begin
      if (m_phase != PH_IDLE) begin
        if (l)      m_col = (m_col + COLS - 1) % COLS;
        else if (r) m_col = (m_col + 1) % COLS;
        else if (u) m_row = (m_row + ROWS - 1) % ROWS;
        else if (d) m_row = (m_row + 1) % ROWS;
      end
      case (m_phase)
        PH_FIRST, PH_SECOND: begin
          if (expired) begin
            for (int i = 0; i < N_CELLS; i++) m_rev[i] = 0;
            m_player = 1 - m_player; m_turn = TURN_CYCLES; m_phase = PH_FIRST;
          end else begin
            m_turn--;
            if (can_sel) begin
              m_rev[cur] = 1;
              if (m_phase == PH_FIRST) begin
                m_a = cur; m_va = int'(rom[cur]); m_phase = PH_SECOND;
              end else begin
                m_b = cur; m_vb = int'(rom[cur]); m_phase = PH_JUDGE;
              end
            end
          end
        end
        PH_JUDGE: begin
          if (m_va == m_vb) begin
            m_mat[m_a] = 1; m_mat[m_b] = 1; m_rev[m_a] = 0; m_rev[m_b] = 0;
            if (m_score[m_player] < 25) m_score[m_player]++;
            all = 1;
            for (int i = 0; i < N_CELLS; i++) if (!m_mat[i]) all = 0;
            if (all) m_phase = PH_OVER;
            else begin m_phase = PH_FIRST; m_turn = TURN_CYCLES; end
          end else begin
            m_phase = PH_HOLD; m_show = SHOW_CYCLES;
          end
        end
        PH_HOLD: begin
          m_show--;
          if (m_show == 0) begin
            m_rev[m_a] = 0; m_rev[m_b] = 0;
            m_player = 1 - m_player; m_turn = TURN_CYCLES; m_phase = PH_FIRST;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [OUT_W-1:0] model_outputs();
    logic [N_CELLS-1:0] rv, mt;
    int secs;
    logic [1:0] w;
    for (int i = 0; i < N_CELLS; i++) begin rv[i] = m_rev[i]; mt[i] = m_mat[i]; end
    secs = (m_turn - 1) / SEC_DIV;
    if (secs > 15) secs = 15;
    w = 2'b00;
    if (m_phase == PH_OVER)
      w = (m_score[0] > m_score[1]) ? 2'b01 : (m_score[1] > m_score[0]) ? 2'b10 : 2'b11;
    return {6'(m_row * COLS + m_col), rv, mt, 1'(m_player), 5'(m_score[0]), 5'(m_score[1]),
            4'(secs), 1'(m_phase == PH_OVER), w};
  endfunction

  function automatic logic [OUT_W-1:0] dut_outputs();
    return {cursor, revealed, matched, player, score_p1, score_p2, timer_left, game_over, winner};
  endfunction

  task automatic tick(input bit st, l, r, u, d, s);
    @(negedge clk);
    start = st; mv_left = l; mv_right = r; mv_up = u; mv_down = d; sel = s;
    model_step(st, l, r, u, d, s);
    @(posedge clk);
    #1;
    check("model", dut_outputs(), model_outputs());
    start = 0; mv_left = 0; mv_right = 0; mv_up = 0; mv_down = 0; sel = 0;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_outputs", dut_outputs(), model_outputs());
    check("reset_revealed", OUT_W'(revealed), OUT_W'(0));
    check("reset_player", OUT_W'(player), OUT_W'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto_cell(input int target);
    int guard = 0;
    while ((m_row * COLS + m_col) != target && guard < 100) begin
      if (m_row != target / COLS) tick(0, 0, 0, 0, 1, 0);
      else                        tick(0, 0, 1, 0, 0, 0);
      guard++;
    end
  endtask

  task automatic pick_pair(input int a, input int b);
    goto_cell(a);
    tick(0, 0, 0, 0, 0, 1);
    goto_cell(b);
    tick(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; mv_left = 0; mv_right = 0; mv_up = 0; mv_down = 0; sel = 0;
    for (int i = 0; i < 64; i++) rom[i] = VAL_W'(i % 25);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Cursor wrap and move priority table
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,  '0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 9,  '0};
    vecs[2]  = '{0, 0, 1, 0, 0, 0, 0,  '0};
    vecs[3]  = '{0, 0, 0, 1, 0, 0, 40, '0};
    vecs[4]  = '{0, 0, 0, 0, 1, 0, 0,  '0};
    vecs[5]  = '{0, 0, 0, 0, 1, 0, 10, '0};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 19, '0};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 10, '0};
    vecs[8]  = '{0, 0, 0, 1, 1, 0, 0,  '0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0,  '0};
    vecs[10] = '{0, 0, 0, 1, 0, 0, 40, '0};
    vecs[11] = '{0, 0, 1, 0, 0, 0, 41, '0};
    vecs[12] = '{0, 0, 1, 0, 0, 0, 42, '0};
    vecs[13] = '{0, 0, 1, 0, 0, 0, 43, '0};
    vecs[14] = '{0, 0, 1, 0, 0, 0, 44, '0};
    vecs[15] = '{0, 0, 1, 0, 0, 0, 45, '0};
    vecs[16] = '{0, 0, 0, 0, 1, 0, 5,  '0};
    vecs[17] = '{0, 0, 1, 0, 0, 0, 6,  '0};
    vecs[18] = '{0, 0, 1, 0, 0, 0, 7,  '0};
    vecs[19] = '{0, 0, 1, 0, 0, 0, 8,  '0};
    vecs[20] = '{0, 0, 1, 0, 0, 0, 9,  '0};
    vecs[21] = '{0, 0, 1, 0, 0, 0, 0,  '0};
    vecs[22] = '{0, 0, 1, 0, 0, 1, 1,  N_CELLS'(1)};
    for (int i = 0; i < 23; i++) begin
      tick(vecs[i].st, vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, vecs[i].s);
      check("vec_cursor", OUT_W'(cursor), OUT_W'(vecs[i].exp_cursor));
      check("vec_revealed", OUT_W'(revealed), OUT_W'(vecs[i].exp_rev));
    end

    // Reset during the mismatch hold, then IDLE ignores everything but start
    do_reset();
    rom[0] = 5'd3; rom[1] = 5'd4;
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    repeat (3) idle();
    check("hold_before_reset", OUT_W'(revealed[1:0]), OUT_W'(2'b11));
    do_reset();
    tick(0, 0, 1, 0, 0, 1);
    check("idle_cursor", OUT_W'(cursor), OUT_W'(0));
    check("idle_revealed", OUT_W'(revealed), OUT_W'(0));
    tick(1, 0, 0, 0, 0, 0);
    check("resume_timer", OUT_W'(timer_left), OUT_W'(9));

    // Matching pair, then select on a matched cell
    do_reset();
    rom[0] = 5'd7; rom[1] = 5'd7;
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    idle();
    check("match_matched", OUT_W'(matched), OUT_W'(50'b11));
    check("match_revealed", OUT_W'(revealed), OUT_W'(0));
    check("match_score_p1", OUT_W'(score_p1), OUT_W'(1));
    check("match_player", OUT_W'(player), OUT_W'(0));
    tick(0, 0, 0, 0, 0, 1);
    check("sel_matched_revealed", OUT_W'(revealed), OUT_W'(0));
    check("sel_matched_matched", OUT_W'(matched), OUT_W'(50'b11));

    // Mismatch hold lasts SHOW_CYCLES, then the turn passes
    do_reset();
    rom[0] = 5'd3; rom[1] = 5'd4;
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < SHOW_CYCLES; i++) begin
      idle();
      check("hold_revealed", OUT_W'(revealed[1:0]), OUT_W'(2'b11));
    end
    idle();
    check("hold_done_revealed", OUT_W'(revealed), OUT_W'(0));
    check("hold_done_player", OUT_W'(player), OUT_W'(1));
    check("hold_done_scores", OUT_W'({score_p1, score_p2}), OUT_W'(0));

    // Turn timeout with one card up; sel on the expiry cycle is dropped
    tick(0, 0, 0, 0, 0, 1);
    check("to_timer_start", OUT_W'(timer_left), OUT_W'(9));
    tick(0, 0, 1, 0, 0, 0);
    for (int k = 3; k <= TURN_CYCLES - 1; k++) begin
      idle();
      if (k == 20) check("to_timer_mid", OUT_W'(timer_left), OUT_W'(4));
    end
    check("to_last_revealed", OUT_W'(revealed), OUT_W'(50'b10));
    check("to_last_timer", OUT_W'(timer_left), OUT_W'(0));
    tick(0, 0, 0, 0, 0, 1);
    check("to_revealed", OUT_W'(revealed), OUT_W'(0));
    check("to_player", OUT_W'(player), OUT_W'(0));
    check("to_timer_reload", OUT_W'(timer_left), OUT_W'(9));

    // Scripted full game: P1 takes 13 pairs, misses once, P2 takes the last 12
    do_reset();
    for (int i = 0; i < N_CELLS; i++) rom[i] = VAL_W'(i / 2);
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) pick_pair(2 * k, 2 * k + 1);
    pick_pair(26, 28);
    repeat (SHOW_CYCLES + 1) idle();
    check("game_turn_passed", OUT_W'(player), OUT_W'(1));
    for (int k = 13; k < 25; k++) pick_pair(2 * k, 2 * k + 1);
    idle();
    check("game_matched", OUT_W'(matched), OUT_W'({N_CELLS{1'b1}}));
    check("game_over", OUT_W'(game_over), OUT_W'(1));
    check("game_winner", OUT_W'(winner), OUT_W'(2'b01));
    check("game_scores", OUT_W'({score_p1, score_p2}), OUT_W'({5'd13, 5'd12}));
    idle();
    check("game_hold_matched", OUT_W'(matched), OUT_W'({N_CELLS{1'b1}}));
    tick(1, 0, 0, 0, 0, 0);
    check("restart_matched", OUT_W'(matched), OUT_W'(0));
    check("restart_scores", OUT_W'({score_p1, score_p2}), OUT_W'(0));
    check("restart_flags", OUT_W'({game_over, winner, player}), OUT_W'(0));
    check("restart_cursor", OUT_W'(cursor), OUT_W'(0));

    // Random play with a small identity alphabet so matches are common
    do_reset();
    for (int i = 0; i < 64; i++) rom[i] = VAL_W'($urandom_range(0, 3));
    tick(1, 0, 0, 0, 0, 0);
    repeat (3000) begin
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_turn_controller.md
Name: memory_turn_controller

Overview:
- Game sequencer for the 10x5 card board drawn on VGA.
- Owns cursor position, face-up/matched card masks, turn ownership, scores and per-turn timeout for a two-player memory (pairs) game.
- Its masks and cursor feed the pixel renderer, which colours each grid cell through the per-cell position-hit decode.
- Card identities come from an external board ROM via a combinational read port.

Parameters:
- COLS, 10, grid columns.
- ROWS, 5, grid rows.
- N_CELLS, 50, total cells; must equal COLS*ROWS.
- VAL_W, 5, card identity width (25 pairs).
- TURN_CYCLES, 250000000, clock cycles allowed per turn (10 s at 25 MHz).
- SHOW_CYCLES, 25000000, hold time for a mismatched pair (1 s).

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a game from IDLE or GAME_OVER
- mv_left, mv_right, mv_up, mv_down  in  1 each  one-cycle debounced move pulses
- sel  in  1  one-cycle pulse; select card under cursor
- val_addr  out  6  = cursor, continuously
- val_data  in  VAL_W  card identity at val_addr, combinational
- cursor  out  6  linear cell index row*COLS+col
- revealed  out  N_CELLS  face-up, unmatched cards
- matched  out  N_CELLS  permanently removed pairs
- player  out  1  0 = P1, 1 = P2
- score_p1, score_p2  out  5 each  pairs won
- timer_left  out  4  whole seconds remaining in turn, saturating, for display
- game_over  out  1  level
- winner  out  2  01 = P1, 10 = P2, 11 = tie, 00 = not over

Behaviour:
- Reset (async, immediate, any state): state=IDLE; cursor=0; revealed=0; matched=0; player=0; scores=0; timers cleared; game_over=0; winner=00.
- States: IDLE, PICK1, PICK2, CHECK, SHOW, GAME_OVER.
- IDLE/GAME_OVER + start -> PICK1: clear masks, scores and player; cursor=0; load turn timer.
- Cursor moves in any state except IDLE:
  - left/right wrap within the row; up/down wrap within the column.
  - Move pulses are one-hot; if several pulses arrive in one cycle, priority is left > right > up > down.
- PICK1 + sel on a cell with revealed=0 and matched=0: set revealed[cursor], latch idxA=cursor and valA=val_data -> PICK2.
- sel on a revealed or matched cell is ignored in every state.
- PICK2 + valid sel: set revealed[cursor], latch idxB and valB -> CHECK.
- sel and a move in the same cycle: the selection uses the pre-move cursor; the move still applies.
- CHECK (1 cycle):
  - valA==valB: set matched bits, clear revealed bits, increment the current player's score, and keep the same player.
    - If matched becomes all ones -> GAME_OVER.
    - Otherwise -> PICK1 with turn timer reloaded.
  - valA!=valB -> SHOW, load show counter.
- SHOW: ignore sel. After SHOW_CYCLES, clear both revealed bits, toggle player, reload turn timer -> PICK1.
- Turn timer:
  - Counts down only in PICK1/PICK2.
  - At 0: clear revealed, toggle player, reload -> PICK1.
  - If sel arrives on the expiry cycle, the timeout wins and the sel is dropped.
- timer_left = remaining/(TURN_CYCLES/10) truncated, capped at 15. Internal counters are 28 bits wide.
- GAME_OVER:
  - game_over=1; winner set by score comparison (11 if equal).
  - Masks and scores hold until start.
- Scores saturate at 25; by construction this is never exceeded.
- No output is combinationally dependent on val_data.

Test Plan:
- Reset mid-SHOW with two cards revealed -> next cycle revealed=0, player=0, state IDLE, start is required to resume.
- ROM with cell0=cell1=7: start, sel, mv_right, sel -> after CHECK matched[1:0]=11, revealed=0, score_p1=1, player=0.
- ROM cell0=3, cell1=4, SHOW_CYCLES=8: two picks -> revealed[1:0]=11 for 8 cycles, then 0; player=1; score unchanged.
- TURN_CYCLES=20: one pick, then idle -> after 20 PICK cycles revealed=0, player toggles; also sel on the expiry cycle is dropped.
- Cursor at 9, mv_right -> 0; cursor 45, mv_down -> 5; sel on an already-matched cell -> no state change.
- Scripted full game, P1 wins 13 pairs and P2 wins 12 -> matched all ones, game_over=1, winner=01; then start clears everything.
